// File: rtl/ppu_2007_ctrl.sv
// ppu_2007_ctrl
// CPU-side sequencer for PPU VRAM access through $2006/$2007.
// Owns the VRAM address v, the temporary address t, the shared write toggle w
// and the $2007 read buffer. Each $2007 access runs IDLE -> WAIT -> ACCESS ->
// HOLD. WAIT holds off the CHR-SRAM visit window until the renderer leaves a
// pattern-table slot free. Nametable and palette addresses (v[13]=1) never wait.
//
// Ports
//   i_cpu_clk, i_cpu_rstn      clock, synchronous active-low reset
//   i_reg_sel/wr/rd/wdata      CPU register decode ($2000+sel)
//   o_reg_rdata                $2007 read data, 0 when i_reg_sel != 7
//   i_inc32                    PPUCTRL increment select (32 or 1)
//   i_pt_slot_free             renderer is not using CHR-SRAM this cycle
//   o_vram_addr/we/wdata       VRAM configuration port
//   i_vram_rdata               VRAM read data, one cycle after the address
//   o_2007_visit               config port owns CHR-SRAM (ACCESS and HOLD)
//   o_busy                     a $2007 sequence is in flight
//   o_overrun                  registered pulse: $2006/$2007 access dropped
//
// Strobe semantics: i_reg_wr / i_reg_rd are single-cycle qualifiers with no
// ready return. The block acts on any strobe it sees. A $2006/$2007 strobe that
// arrives while o_busy is high is discarded and reported on o_overrun in the
// next cycle. $2002 reads and $2005 writes always act on the toggle.
module ppu_2007_ctrl (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [2:0]  i_reg_sel,
  input  logic        i_reg_wr,
  input  logic        i_reg_rd,
  input  logic [7:0]  i_reg_wdata,
  output logic [7:0]  o_reg_rdata,
  input  logic        i_inc32,
  input  logic        i_pt_slot_free,
  output logic [15:0] o_vram_addr,
  output logic        o_vram_we,
  output logic [7:0]  o_vram_wdata,
  input  logic [7:0]  i_vram_rdata,
  output logic        o_2007_visit,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] v_q, v_d;
  logic [13:0] t_q, t_d;
  logic        w_q, w_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        op_rd_q, op_rd_d;
  logic        overrun_q, overrun_d;

  logic rd_2002, wr_2005, wr_2006, acc_2007;
  logic busy;
  logic v_is_pal;

  assign rd_2002  = i_reg_rd && (i_reg_sel == 3'd2);
  assign wr_2005  = i_reg_wr && (i_reg_sel == 3'd5);
  assign wr_2006  = i_reg_wr && (i_reg_sel == 3'd6);
  assign acc_2007 = (i_reg_wr || i_reg_rd) && (i_reg_sel == 3'd7);
  assign busy     = (state_q != ST_IDLE);
  assign v_is_pal = (v_q[13:8] == 6'h3F);

  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) begin
      state_q   <= ST_IDLE;
      v_q       <= 14'h0000;
      t_q       <= 14'h0000;
      w_q       <= 1'b0;
      rbuf_q    <= 8'h00;
      wdata_q   <= 8'h00;
      op_rd_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      t_q       <= t_d;
      w_q       <= w_d;
      rbuf_q    <= rbuf_d;
      wdata_q   <= wdata_d;
      op_rd_q   <= op_rd_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    t_d       = t_q;
    w_d       = w_q;
    rbuf_d    = rbuf_q;
    wdata_d   = wdata_q;
    op_rd_d   = op_rd_q;
    overrun_d = busy && (wr_2006 || acc_2007);

    // Toggle maintenance is independent of the sequencer.
    if (rd_2002) w_d = 1'b0;
    if (wr_2005) w_d = ~w_q;

    // $2006 is blocked while busy so v never moves under a live access.
    if (wr_2006 && !busy) begin
      if (!w_q) begin
        t_d[13:8] = i_reg_wdata[5:0];
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = i_reg_wdata;
        v_d      = {t_q[13:8], i_reg_wdata};
        w_d      = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (acc_2007) begin
          op_rd_d = !i_reg_wr;
          wdata_d = i_reg_wr ? i_reg_wdata : 8'h00;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Nametable/palette space is not shared with the renderer's CHR slots.
        if (v_q[13] || i_pt_slot_free) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_HOLD;
      ST_HOLD: begin
        if (op_rd_q) rbuf_d = i_vram_rdata;
        v_d     = v_q + (i_inc32 ? 14'd32 : 14'd1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Palette reads refill the buffer from the nametable mirrored underneath.
  always_comb begin
    o_vram_addr = {2'b00, v_q};
    if (op_rd_q && v_is_pal && (state_q == ST_ACCESS || state_q == ST_HOLD))
      o_vram_addr = {2'b00, v_q & 14'h2FFF};
  end

  assign o_vram_we    = (state_q == ST_ACCESS) && !op_rd_q;
  assign o_vram_wdata = o_vram_we ? wdata_q : 8'h00;
  assign o_2007_visit = (state_q == ST_ACCESS) || (state_q == ST_HOLD);
  assign o_busy       = busy;
  assign o_overrun    = overrun_q;

  // Palette data comes straight from VRAM. Everything else returns the
  // buffered byte from the previous read.
  always_comb begin
    o_reg_rdata = 8'h00;
    if (i_reg_sel == 3'd7) o_reg_rdata = v_is_pal ? i_vram_rdata : rbuf_q;
  end

endmodule

// File: tb/tb_ppu_2007_ctrl.sv
// Testbench for ppu_2007_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and a randomized phase checked against an
// address/buffer reference model.
module tb_ppu_2007_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  reg_sel = 3'd0;
  logic        reg_wr = 1'b0, reg_rd = 1'b0;
  logic [7:0]  reg_wdata = 8'h00;
  logic [7:0]  reg_rdata;
  logic        inc32 = 1'b0, slot_free = 1'b1;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        visit, busy, overrun;

  ppu_2007_ctrl dut (
    .i_cpu_clk(clk), .i_cpu_rstn(rstn),
    .i_reg_sel(reg_sel), .i_reg_wr(reg_wr), .i_reg_rd(reg_rd),
    .i_reg_wdata(reg_wdata), .o_reg_rdata(reg_rdata),
    .i_inc32(inc32), .i_pt_slot_free(slot_free),
    .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_wdata(vram_wdata),
    .i_vram_rdata(vram_rdata), .o_2007_visit(visit), .o_busy(busy),
    .o_overrun(overrun)
  );

  // ---------------- VRAM environment ----------------
  logic [7:0]  vmem [0:16383];
  logic        clr_en = 1'b0, pl_en = 1'b0;
  logic [13:0] pl_addr = 14'h0;
  logic [7:0]  pl_data = 8'h0;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int a = 0; a < 16384; a++) vmem[a] <= 8'h00;
    end else if (pl_en) begin
      vmem[pl_addr] <= pl_data;
    end else if (vram_we) begin
      vmem[vram_addr[13:0]] <= vram_wdata;
    end
    vram_rdata <= vmem[vram_addr[13:0]];
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  bit rand_slot = 1'b0;

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic do_strobe(input logic [2:0] sel, input logic wr, input logic [7:0] d,
                           output logic [7:0] rdat);
    @(negedge clk);
    reg_sel = sel; reg_wr = wr; reg_rd = !wr; reg_wdata = d;
    #1 rdat = reg_rdata;
    @(posedge clk); #1 reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else if (rand_slot) slot_free = ($urandom_range(0, 3) != 0);
    end
    if (!done) check("wait_idle_timeout", 32'd1, 32'd0);
    slot_free = 1'b1;
  endtask

  task automatic wr_v(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] r;
    do_strobe(3'd6, 1'b1, hi, r); wait_idle();
    do_strobe(3'd6, 1'b1, lo, r); wait_idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  sel;
    logic        wr;
    logic [7:0]  d;
    logic        inc32;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic [15:0] exp_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic av(input logic [2:0] sel, input logic wr, input logic [7:0] d,
                    input logic i32, input logic chk, input logic [7:0] er,
                    input logic [15:0] ea);
    vec_t v;
    v.sel = sel; v.wr = wr; v.d = d; v.inc32 = i32;
    v.chk_rd = chk; v.exp_rd = er; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [13:0] m_v, m_t;
  logic        m_w;
  logic [7:0]  m_rbuf;
  logic [7:0]  ref_mem [0:16383];

  task automatic model_op(input logic [2:0] sel, input logic wr, input logic [7:0] d,
                          input logic i32, output logic [7:0] er);
    int pal;
    er = 8'h00;
    if (sel == 3'd2 && !wr) m_w = 1'b0;
    else if (sel == 3'd5 && wr) m_w = !m_w;
    else if (sel == 3'd6 && wr) begin
      if (!m_w) begin m_t = {d[5:0], m_t[7:0]}; m_w = 1'b1; end
      else begin m_t = {m_t[13:8], d}; m_v = m_t; m_w = 1'b0; end
    end else if (sel == 3'd7) begin
      if (wr) ref_mem[m_v] = d;
      else begin
        pal = (m_v >= 14'h3F00) ? 1 : 0;
        er = pal ? ref_mem[m_v] : m_rbuf;
        // Palette reads refill from the nametable 0x1000 below.
        m_rbuf = ref_mem[pal ? int'(m_v) - 32'h1000 : int'(m_v)];
      end
      m_v = 14'((int'(m_v) + (i32 ? 32 : 1)) % 16384);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] r, er;
    logic [2:0] sel;
    logic wr;
    logic [7:0] d;
    int diffs;

    exp_q.delete();
    @(negedge clk); clr_en = 1'b1;
    @(posedge clk); #1 clr_en = 1'b0;
    preload(14'h2000, 8'hAA); preload(14'h2001, 8'hBB);
    preload(14'h3F01, 8'h16); preload(14'h2F01, 8'h77);
    preload(14'h3FFF, 8'h0C); preload(14'h2FFF, 8'h5A);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    @(negedge clk); reg_sel = 3'd7;
    #1;
    check("rst_addr", vram_addr, 16'h0000);
    check("rst_we", vram_we, 1'b0);
    check("rst_wdata", vram_wdata, 8'h00);
    check("rst_visit", visit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_rdata", reg_rdata, 8'h00);

    // Directed table
    av(6, 1, 8'h20, 0, 0, 0, 16'h0000);
    av(6, 1, 8'h00, 0, 0, 0, 16'h2000);
    av(7, 0, 8'h00, 0, 1, 8'h00, 16'h2001);
    av(7, 0, 8'h00, 0, 1, 8'hAA, 16'h2002);
    av(7, 0, 8'h00, 0, 1, 8'hBB, 16'h2003);
    av(6, 1, 8'h24, 0, 0, 0, 16'h2003);
    av(6, 1, 8'h00, 0, 0, 0, 16'h2400);
    av(7, 1, 8'h55, 0, 0, 0, 16'h2401);
    av(6, 1, 8'h23, 0, 0, 0, 16'h2401);
    av(6, 1, 8'hE0, 0, 0, 0, 16'h23E0);
    av(7, 0, 8'h00, 1, 1, 8'h00, 16'h2400);
    av(6, 1, 8'h3F, 0, 0, 0, 16'h2400);
    av(6, 1, 8'hFF, 0, 0, 0, 16'h3FFF);
    av(7, 0, 8'h00, 0, 1, 8'h0C, 16'h0000);
    av(6, 1, 8'h3F, 0, 0, 0, 16'h0000);
    av(6, 1, 8'h01, 0, 0, 0, 16'h3F01);
    av(7, 0, 8'h00, 0, 1, 8'h16, 16'h3F02);
    av(6, 1, 8'h21, 0, 0, 0, 16'h3F02);
    av(6, 1, 8'h00, 0, 0, 0, 16'h2100);
    av(7, 0, 8'h00, 0, 1, 8'h77, 16'h2101);
    av(6, 1, 8'h21, 0, 0, 0, 16'h2101);
    av(2, 0, 8'h00, 0, 1, 8'h00, 16'h2101);
    av(6, 1, 8'h3F, 0, 0, 0, 16'h2101);
    av(6, 1, 8'h00, 0, 0, 0, 16'h3F00);
    av(5, 1, 8'h77, 0, 0, 0, 16'h3F00);
    av(6, 1, 8'h12, 0, 0, 0, 16'h3F12);

    foreach (vecs[i]) begin
      inc32 = vecs[i].inc32;
      do_strobe(vecs[i].sel, vecs[i].wr, vecs[i].d, r);
      wait_idle();
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      check($sformatf("vec%0d_addr", i), vram_addr, vecs[i].exp_addr);
    end
    check("vram_2400", vmem[14'h2400], 8'h55);
    inc32 = 1'b0;

    // Write timing: one we cycle, two visit cycles
    wr_v(8'h24, 8'h10);
    do_strobe(3'd7, 1'b1, 8'h66, r);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("wt_busy_k%0d", k), busy, (k <= 3));
      check($sformatf("wt_visit_k%0d", k), visit, (k == 2 || k == 3));
      check($sformatf("wt_we_k%0d", k), vram_we, (k == 2));
      check($sformatf("wt_wdata_k%0d", k), vram_wdata, (k == 2) ? 8'h66 : 8'h00);
      if (k == 2) check("wt_addr_access", vram_addr, 16'h2410);
      if (k == 4) check("wt_addr_after", vram_addr, 16'h2411);
    end

    // Palette read: mirrored nametable address during ACCESS/HOLD
    wr_v(8'h3F, 8'h01);
    do_strobe(3'd7, 1'b0, 8'h00, r);
    check("pal_rdata", r, 8'h16);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2 || k == 3) check($sformatf("pal_addr_k%0d", k), vram_addr, 16'h2F01);
      if (k == 4) check("pal_addr_after", vram_addr, 16'h3F02);
    end
    wr_v(8'h21, 8'h00);
    do_strobe(3'd7, 1'b0, 8'h00, r); wait_idle();
    check("pal_rbuf_refill", r, 8'h77);

    // Slot wait plus overrun while busy
    wr_v(8'h00, 8'h10);
    slot_free = 1'b0;
    do_strobe(3'd7, 1'b0, 8'h00, r);
    @(negedge clk);
    check("sw_k1_visit", visit, 1'b0);
    check("sw_k1_busy", busy, 1'b1);
    do_strobe(3'd7, 1'b0, 8'h00, r);
    @(negedge clk);
    check("sw_overrun_hi", overrun, 1'b1);
    check("sw_k3_visit", visit, 1'b0);
    check("sw_k3_busy", busy, 1'b1);
    @(negedge clk);
    check("sw_overrun_lo", overrun, 1'b0);
    check("sw_k4_visit", visit, 1'b0);
    @(negedge clk);
    check("sw_k5_visit", visit, 1'b0);
    slot_free = 1'b1;
    @(negedge clk);
    check("sw_visit_rise", visit, 1'b1);
    wait_idle();
    check("sw_addr_single", vram_addr, 16'h0011);
    repeat (3) @(negedge clk);
    check("sw_no_second", busy, 1'b0);
    check("sw_addr_hold", vram_addr, 16'h0011);

    // Randomized phase against the reference model
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    m_v = 14'h0; m_t = 14'h0; m_w = 1'b0; m_rbuf = 8'h00;
    for (int a = 0; a < 16384; a++) ref_mem[a] = vmem[a];
    rand_slot = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       begin sel = 3'd2; wr = 1'b0; end
        1:       begin sel = 3'd5; wr = 1'b1; end
        2, 3, 4: begin sel = 3'd6; wr = 1'b1; end
        5, 6:    begin sel = 3'd7; wr = 1'b1; end
        7, 8:    begin sel = 3'd7; wr = 1'b0; end
        default: begin sel = 3'd0; wr = 1'b1; end
      endcase
      d = 8'($urandom);
      if (sel == 3'd6 && $urandom_range(0, 3) == 0) d = 8'h3F;
      inc32 = 1'($urandom_range(0, 1));
      slot_free = ($urandom_range(0, 3) != 0);
      model_op(sel, wr, d, inc32, er);
      if (!wr) exp_q.push_back(er);
      do_strobe(sel, wr, d, r);
      wait_idle();
      if (!wr) check($sformatf("rnd%0d_rdata", i), r, exp_q.pop_front());
      check($sformatf("rnd%0d_addr", i), vram_addr, {2'b00, m_v});
    end
    rand_slot = 1'b0;
    inc32 = 1'b0;
    diffs = 0;
    for (int a = 0; a < 16384; a++) if (vmem[a] !== ref_mem[a]) diffs++;
    check("rnd_vram_contents", diffs, 0);

    // Reset during HOLD
    wr_v(8'h20, 8'h00);
    do_strobe(3'd7, 1'b0, 8'h00, r);
    repeat (3) @(negedge clk);
    check("rh_in_hold", visit, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rh_addr", vram_addr, 16'h0000);
    check("rh_visit", visit, 1'b0);
    check("rh_we", vram_we, 1'b0);
    check("rh_busy", busy, 1'b0);
    check("rh_overrun", overrun, 1'b0);
    check("rh_rdata", reg_rdata, 8'h00);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("rh_addr_after", vram_addr, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
